long_divider: RTL and testbench

Parametrised sequential restoring long divider producing one quotient bit per clock. Accepts a dividend/divisor pair through a valid/ready handshake, iterates for `DATA_WIDTH` cycles, then holds quotient, remainder and a divide-by-zero flag until the consumer accepts them. It is the general-width, handshaked successor of the team's fixed 8-bit `longDivision` block and sits in the DSP filter datapath wherever normalisation or gain division is needed.

---
 rtl/long_divider.sv | 220 ++++++++++++++++++++++
 tb/tb_long_divider.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/long_divider.sv
`default_nettype none
// ============================================================================
//  Module      : long_divider
//  Description : Sequential restoring long divider, one quotient bit per
//                clock, with valid/ready handshakes on operands and results.
//                Optional two's-complement mode when LONG_DIVIDER_SIGNED_EN
//                is defined (adds a FIXUP state and sign-correction logic).
//  Ports       : i_clk, i_reset        clock, synchronous active-high reset
//                i_valid / o_ready     operand handshake (ready only in IDLE)
//                i_dividend, i_divisor operands, DATA_WIDTH bits
//                o_valid / i_ready     result handshake (valid only in DONE)
//                o_quotient,
//                o_remainder           results, held until accepted
//                o_div_by_zero         divisor was zero for this result
//  Revision    : 1.0  initial release
// ============================================================================
module long_divider #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder,
  output logic                  o_div_by_zero
);

  // The first quotient bit is produced on the accept edge, so DIVIDE only
  // needs DATA_WIDTH-1 further iterations; the counter therefore tops out
  // at DATA_WIDTH-2.
  localparam int                c_CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH - 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(DATA_WIDTH - 2);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FIXUP  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [c_CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;      // partial remainder
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;  // dividend bits out, quotient bits in
  logic [DATA_WIDTH-1:0]   dvsr_q, dvsr_d;    // divisor (magnitude)
  logic [DATA_WIDTH-1:0]   quot_q, quot_d;
  logic [DATA_WIDTH-1:0]   remo_q, remo_d;
  logic                    dbz_q, dbz_d;
`ifdef LONG_DIVIDER_SIGNED_EN
  logic                    negq_q, negq_d;    // quotient must be negated
  logic                    negr_q, negr_d;    // remainder must be negated
`endif

  // --------------------------------------------------------------------------
  // Operand conditioning
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_dvd_mag;
  logic [DATA_WIDTH-1:0] w_dvs_mag;
`ifdef LONG_DIVIDER_SIGNED_EN
  logic                  w_dvd_neg;
  logic                  w_dvs_neg;
  assign w_dvd_neg = i_dividend[DATA_WIDTH-1];
  assign w_dvs_neg = i_divisor[DATA_WIDTH-1];
  // MIN maps to 2^(W-1), which still fits as an unsigned W-bit magnitude.
  assign w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
  assign w_dvs_mag = w_dvs_neg ? -i_divisor  : i_divisor;
`else
  assign w_dvd_mag = i_dividend;
  assign w_dvs_mag = i_divisor;
`endif

  // --------------------------------------------------------------------------
  // One restoring iteration, shared by the accept edge and DIVIDE
  // --------------------------------------------------------------------------
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_rem_src;
  logic [DATA_WIDTH-1:0] w_shift_src;
  logic [DATA_WIDTH-1:0] w_dvsr_src;
  logic [DATA_WIDTH:0]   w_trial;
  logic                  w_qbit;
  logic [DATA_WIDTH-1:0] w_rem_next;
  logic [DATA_WIDTH-1:0] w_shift_next;

  assign w_load      = (state_q == S_IDLE);
  assign w_rem_src   = w_load ? '0        : rem_q;
  assign w_shift_src = w_load ? w_dvd_mag : shift_q;
  assign w_dvsr_src  = w_load ? w_dvs_mag : dvsr_q;

  // The full W-bit partial remainder is shifted so a remainder with its top
  // bit set (possible with large divisors) is not truncated; the extra bit
  // of the W+1 wide difference is the borrow.
  assign w_trial      = {w_rem_src, w_shift_src[DATA_WIDTH-1]} - {1'b0, w_dvsr_src};
  assign w_qbit       = ~w_trial[DATA_WIDTH];
  // On a failed trial the shifted value is below the divisor, so its top
  // bit is zero and dropping it is lossless.
  assign w_rem_next   = w_qbit ? w_trial[DATA_WIDTH-1:0]
                               : {w_rem_src[DATA_WIDTH-2:0], w_shift_src[DATA_WIDTH-1]};
  assign w_shift_next = {w_shift_src[DATA_WIDTH-2:0], w_qbit};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      shift_q <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
`ifdef LONG_DIVIDER_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      shift_q <= shift_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
`ifdef LONG_DIVIDER_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    shift_d = shift_q;
    dvsr_d  = dvsr_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
`ifdef LONG_DIVIDER_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          dbz_d = (i_divisor == '0);
          if (i_divisor == '0) begin
            quot_d  = '1;
            remo_d  = i_dividend;
            state_d = S_DONE;
          end else begin
            rem_d   = w_rem_next;
            shift_d = w_shift_next;
            dvsr_d  = w_dvs_mag;
            cnt_d   = c_CNT_INIT;
`ifdef LONG_DIVIDER_SIGNED_EN
            negq_d  = w_dvd_neg ^ w_dvs_neg;
            negr_d  = w_dvd_neg;
`endif
            state_d = S_DIVIDE;
          end
        end
      end

      S_DIVIDE: begin
        rem_d   = w_rem_next;
        shift_d = w_shift_next;
        cnt_d   = cnt_q - c_CNT_ONE;
        if (cnt_q == '0) begin
`ifdef LONG_DIVIDER_SIGNED_EN
          state_d = S_FIXUP;
`else
          quot_d  = w_shift_next;
          remo_d  = w_rem_next;
          state_d = S_DONE;
`endif
        end
      end

`ifdef LONG_DIVIDER_SIGNED_EN
      S_FIXUP: begin
        quot_d  = negq_q ? -shift_q : shift_q;
        remo_d  = negr_q ? -rem_q   : rem_q;
        state_d = S_DONE;
      end
`endif

      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_ready       = (state_q == S_IDLE);
  assign o_valid       = (state_q == S_DONE);
  assign o_quotient    = quot_q;
  assign o_remainder   = remo_q;
  assign o_div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_long_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_long_divider
//  Description : Scoreboard testbench for long_divider (8- and 16-bit
//                instances). Stimulus pushes expected results; monitors pop
//                and compare whenever a DUT presents o_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_long_divider;

`ifdef LONG_DIVIDER_SIGNED_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v8, rdy8, rd8, vo8, dz8;
  logic [7:0]  a8, b8, q8, r8;
  logic        v16, rdy16, rd16, vo16, dz16;
  logic [15:0] a16, b16, q16, r16;

  long_divider #(.DATA_WIDTH(8)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_valid(v8), .o_ready(rdy8),
    .i_dividend(a8), .i_divisor(b8), .o_valid(vo8), .i_ready(rd8),
    .o_quotient(q8), .o_remainder(r8), .o_div_by_zero(dz8)
  );

  long_divider #(.DATA_WIDTH(16)) dut16 (
    .i_clk(clk), .i_reset(rst), .i_valid(v16), .o_ready(rdy16),
    .i_dividend(a16), .i_divisor(b16), .o_valid(vo16), .i_ready(rd16),
    .o_quotient(q16), .o_remainder(r16), .o_div_by_zero(dz16)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb8[$];
  exp_t sb16[$];
  bit   seen8  = 1'b0;
  bit   seen16 = 1'b0;

  // a, b, q, r bytes
`ifdef LONG_DIVIDER_SIGNED_EN
  localparam logic [31:0] VEC8 [9] = '{
    32'h9C07_F2FE, 32'h80FF_8000, 32'h64F9_F202, 32'h9CF9_0EFE, 32'h8000_FF80,
    32'h079C_0007, 32'h0A03_0301, 32'hFFFF_0100, 32'h7F01_7F00};
`else
  localparam logic [31:0] VEC8 [9] = '{
    32'h6407_0E02, 32'hFF01_FF00, 32'h5A00_FF5A, 32'h0A03_0301, 32'h07C8_0007,
    32'hFFFF_0100, 32'hFFFE_0101, 32'h0005_0000, 32'hC864_0200};
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge, well clear of sampling.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input bit w16, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input bit push);
    exp_t e;
    int   n;
    n = 0;
    if (w16) begin v16 = 1'b1; a16 = a; b16 = b; end
    else     begin v8  = 1'b1; a8  = a[7:0]; b8 = b[7:0]; end
    while ((w16 ? rdy16 : rdy8) !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
    end
    tick();
    if (w16) v16 = 1'b0; else v8 = 1'b0;
    if (push) begin
      e.q   = eq;
      e.r   = er;
      e.dbz = (b == 16'h0);
      e.lat = (b == 16'h0) ? 1 : ((w16 ? 16 : 8) + EXTRA);
      e.acc = cyc;
      if (w16) sb16.push_back(e); else sb8.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb8.size() != 0 || sb16.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb8.size() + sb16.size());
    end
  endtask

  function automatic void ref16(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r);
`ifdef LONG_DIVIDER_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == 16'h0) begin
      q = 16'hFFFF;
      r = a;
    end else begin
`ifdef LONG_DIVIDER_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      q  = 16'(sa / sb);
      r  = 16'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
    end
  endfunction

  // Monitors
  always @(negedge clk) begin
    if (!rst && vo8) begin
      check("ready_valid_excl8", {31'h0, rdy8}, 32'h0);
      if (sb8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid8: got q=%0h r=%0h expected no result", q8, r8);
      end else begin
        check("quot8", {24'h0, q8}, {24'h0, sb8[0].q[7:0]});
        check("rem8",  {24'h0, r8}, {24'h0, sb8[0].r[7:0]});
        check("dbz8",  {31'h0, dz8}, {31'h0, sb8[0].dbz});
        if (!seen8) begin
          check("latency8", cyc - sb8[0].acc + 1, sb8[0].lat);
          seen8 = 1'b1;
        end
        if (rd8) begin
          void'(sb8.pop_front());
          seen8 = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && vo16) begin
      check("ready_valid_excl16", {31'h0, rdy16}, 32'h0);
      if (sb16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid16: got q=%0h r=%0h expected no result", q16, r16);
      end else begin
        check("quot16", {16'h0, q16}, {16'h0, sb16[0].q});
        check("rem16",  {16'h0, r16}, {16'h0, sb16[0].r});
        check("dbz16",  {31'h0, dz16}, {31'h0, sb16[0].dbz});
        if (!seen16) begin
          check("latency16", cyc - sb16[0].acc + 1, sb16[0].lat);
          seen16 = 1'b1;
        end
        if (rd16) begin
          void'(sb16.pop_front());
          seen16 = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [31:0] vec;
    logic [15:0] ra, rb, rq, rr;
    int          n;

    rst = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; rd8 = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; rd16 = 1'b1;
    tick(); tick(); tick();

    // Reset state
    check("rst_ready8", {31'h0, rdy8}, 32'h1);
    check("rst_valid8", {31'h0, vo8},  32'h0);
    check("rst_quot8",  {24'h0, q8},   32'h0);
    check("rst_rem8",   {24'h0, r8},   32'h0);
    check("rst_dbz8",   {31'h0, dz8},  32'h0);
    check("rst_ready16", {31'h0, rdy16}, 32'h1);
    rst = 1'b0;
    tick();

    // Directed 8-bit vectors, back to back
    for (int i = 0; i < 9; i++) begin
      vec = VEC8[i];
      issue(1'b0, {8'h0, vec[31:24]}, {8'h0, vec[23:16]},
            {8'h0, vec[15:8]}, {8'h0, vec[7:0]}, 1'b1);
    end
    drain();

    // Backpressure: result must hold while i_ready is low
    rd8 = 1'b0;
`ifdef LONG_DIVIDER_SIGNED_EN
    issue(1'b0, 16'd200, 16'd9, 16'h00FA, 16'h00FE, 1'b1);
`else
    issue(1'b0, 16'd200, 16'd9, 16'h0016, 16'h0002, 1'b1);
`endif
    n = 0;
    while (vo8 !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("bp_valid_rise", {31'h0, vo8}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ready_low", {31'h0, rdy8}, 32'h0);
      check("bp_valid_held", {31'h0, vo8}, 32'h1);
    end
    rd8 = 1'b1;
    tick();
    check("bp_release_ready", {31'h0, rdy8}, 32'h1);
    check("bp_release_valid", {31'h0, vo8},  32'h0);
    drain();

    // Reset in the middle of a division
    issue(1'b0, 16'd250, 16'd3, 16'h0, 16'h0, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("midrst_ready", {31'h0, rdy8}, 32'h1);
    check("midrst_valid", {31'h0, vo8},  32'h0);
    check("midrst_quot",  {24'h0, q8},   32'h0);
    check("midrst_rem",   {24'h0, r8},   32'h0);
    check("midrst_dbz",   {31'h0, dz8},  32'h0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    issue(1'b0, 16'd9, 16'd4, 16'd2, 16'd1, 1'b1);
    drain();

    // 16-bit directed vector
`ifdef LONG_DIVIDER_SIGNED_EN
    issue(1'b1, 16'hFFFF, 16'h0101, 16'h0000, 16'hFFFF, 1'b1);
    issue(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1);
`else
    issue(1'b1, 16'hFFFF, 16'h0101, 16'h00FF, 16'h0000, 1'b1);
    issue(1'b1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b1);
`endif
    drain();

    // Random 16-bit vectors against the reference model
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 7))
        0:       rb = 16'h0;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = 16'hFFFF - 16'($urandom_range(0, 15));
        default: rb = 16'($urandom_range(0, 65535));
      endcase
      ref16(ra, rb, rq, rr);
      issue(1'b1, ra, rb, rq, rr, 1'b1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
